// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage, one outstanding memory read, hands words to ID.
//   clk_in         system clock, rising edge
//   rst_in         synchronous active-low reset
//   rdy_in         global ready, 0 freezes all state
//   pc_in          fetch address from pc unit
//   branch_or_not  redirect from ex, in-flight fetch becomes stale
//   stall_in       stall vector, bit 1 blocks the IF->ID hand-off
//   mem_req_out    registered read request
//   mem_addr_out   registered read address, also the pc of the word in flight
//   mem_done_in    one-cycle read-complete pulse
//   mem_data_in    fetched word, valid with mem_done_in
//   stall_req_out  combinational request to freeze pc
//   if_valid_out   one-cycle delivery pulse to ID
//   if_pc_out      pc of delivered instruction
//   if_inst_out    delivered instruction
module if_fetch #(
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] pc_in,
   input  logic        branch_or_not,
   input  logic [5:0]  stall_in,
   output logic        mem_req_out,
   output logic [31:0] mem_addr_out,
   input  logic        mem_done_in,
   input  logic [31:0] mem_data_in,
   output logic        stall_req_out,
   output logic        if_valid_out,
   output logic [31:0] if_pc_out,
   output logic [31:0] if_inst_out
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DISCARD = 2'd3;
   logic [1:0]  state;
   logic [31:0] hold_inst;
   logic        unused_stall;
   assign unused_stall = ^{stall_in[5:2], stall_in[0]};
   // pc may advance only when a word is leaving (or parked for) delivery
   assign stall_req_out = !(state == HOLD || (state == WAIT && mem_done_in && !branch_or_not));
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         mem_req_out  <= 1'b0;
         mem_addr_out <= 32'h0;
         hold_inst    <= 32'h0;
         if_valid_out <= 1'b0;
         if_pc_out    <= 32'h0;
         if_inst_out  <= NOP_INST;
      end else if (rdy_in) begin
         if_valid_out <= 1'b0;
         case (state)
            IDLE: if (!branch_or_not) begin
               mem_addr_out <= pc_in;
               mem_req_out  <= 1'b1;
               state        <= WAIT;
            end
            WAIT: if (mem_done_in) begin
               mem_req_out <= 1'b0;
               state       <= IDLE;
               if (!branch_or_not && stall_in[1]) begin
                  hold_inst <= mem_data_in;
                  state     <= HOLD;
               end else if (!branch_or_not) begin
                  if_valid_out <= 1'b1;
                  if_pc_out    <= mem_addr_out;
                  if_inst_out  <= mem_data_in;
               end
            end else if (branch_or_not) begin
               state <= DISCARD;
            end
            HOLD: if (branch_or_not) begin
               hold_inst <= 32'h0;
               state     <= IDLE;
            end else if (!stall_in[1]) begin
               if_valid_out <= 1'b1;
               if_pc_out    <= mem_addr_out;
               if_inst_out  <= hold_inst;
               hold_inst    <= 32'h0;
               state        <= IDLE;
            end
            default: if (mem_done_in) begin
               mem_req_out <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized self-checking bench for if_fetch against a transaction-level model.
module tb_if_fetch;
   localparam logic [31:0] NOP = 32'h00000013;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0, rdy_in = 1'b1, branch_or_not = 1'b0, mem_done_in = 1'b0;
   logic [5:0]  stall_in = 6'h0;
   logic [31:0] pc_in = 32'h0, mem_data_in = 32'h0;
   logic        mem_req_out, stall_req_out, if_valid_out;
   logic [31:0] mem_addr_out, if_pc_out, if_inst_out;
   logic        b_rst, b_rdy, b_br, b_done;
   logic [5:0]  b_stall;
   logic [31:0] b_pc, b_data;
   logic        m_busy, m_stale, m_held;
   logic [31:0] m_raddr, m_hword, e_pc, e_inst;
   logic        e_valid;
   int          n_chk = 0, n_pass = 0;
   int          mem_cnt = 0;
   if_fetch #(.NOP_INST(NOP)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc_in(pc_in),
      .branch_or_not(branch_or_not), .stall_in(stall_in),
      .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
      .mem_done_in(mem_done_in), .mem_data_in(mem_data_in),
      .stall_req_out(stall_req_out), .if_valid_out(if_valid_out),
      .if_pc_out(if_pc_out), .if_inst_out(if_inst_out)
   );
   always #5 clk_in = ~clk_in;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask
   task automatic deliver(input logic [31:0] pc, input logic [31:0] w);
      e_valid = 1'b1;
      e_pc    = pc;
      e_inst  = w;
   endtask
   // Model: a request is either absent or in flight (possibly stale); a finished
   // word can be parked while ID is stalled. Delivery is the only thing visible to ID.
   task automatic model_edge();
      if (!b_rst) begin
         m_busy = 0; m_stale = 0; m_held = 0; m_raddr = 0; m_hword = 0;
         e_valid = 0; e_pc = 0; e_inst = NOP;
      end else if (b_rdy) begin
         e_valid = 0;
         if (m_held) begin
            if (!b_br && !b_stall[1]) deliver(m_raddr, m_hword);
            if (b_br || !b_stall[1]) m_held = 0;
         end else if (m_busy) begin
            if (b_done) begin
               m_busy = 0;
               if (!m_stale && !b_br) begin
                  if (b_stall[1]) begin m_held = 1; m_hword = b_data; end
                  else deliver(m_raddr, b_data);
               end
            end else if (b_br) m_stale = 1;
         end else if (!b_br) begin
            m_busy = 1; m_stale = 0; m_raddr = b_pc;
         end
      end
   endtask
   task automatic step();
      logic es;
      @(negedge clk_in);
      rst_in = b_rst; rdy_in = b_rdy; branch_or_not = b_br; stall_in = b_stall;
      pc_in = b_pc; mem_done_in = b_done; mem_data_in = b_data;
      #1;
      es = !(m_held || (m_busy && !m_stale && b_done && !b_br));
      chk("stall_req", 32'(stall_req_out), 32'(es));
      model_edge();
      @(posedge clk_in);
      #1;
      chk("mem_req", 32'(mem_req_out), 32'(m_busy));
      chk("mem_addr", mem_addr_out, m_raddr);
      chk("if_valid", 32'(if_valid_out), 32'(e_valid));
      chk("if_pc", if_pc_out, e_pc);
      chk("if_inst", if_inst_out, e_inst);
   endtask
   task automatic cyc(input logic br, input logic st, input logic dn, input logic [31:0] pc, input logic [31:0] d);
      b_rst = 1; b_rdy = 1; b_br = br; b_stall = {4'h0, st, 1'b0}; b_done = dn; b_pc = pc; b_data = d;
      step();
   endtask
   initial begin
      logic pb;
      m_busy = 0; m_stale = 0; m_held = 0; m_raddr = 0; m_hword = 0;
      e_valid = 0; e_pc = 0; e_inst = NOP;
      b_rst = 0; b_rdy = 1; b_br = 0; b_stall = 0; b_done = 0; b_pc = 0; b_data = 0;
      step();
      chk("reset_inst", if_inst_out, NOP);
      // fetch at 0 with memory latency 4, then next address 4
      cyc(0, 0, 0, 32'h0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 1, 32'h0, 32'h00500093);
      chk("lat4_valid", 32'(if_valid_out), 32'd1);
      chk("lat4_inst", if_inst_out, 32'h00500093);
      chk("lat4_req_low", 32'(mem_req_out), 32'd0);
      cyc(0, 0, 0, 32'h4, 0);
      chk("next_addr", mem_addr_out, 32'h4);
      // done while ID stalled for 3 cycles
      cyc(0, 0, 0, 32'h4, 0);
      cyc(0, 1, 1, 32'h4, 32'hdeadbeef);
      chk("hold_no_pulse", 32'(if_valid_out), 32'd0);
      cyc(0, 1, 0, 32'h8, 0);
      cyc(0, 1, 0, 32'h8, 0);
      cyc(0, 0, 0, 32'h8, 0);
      chk("hold_release_inst", if_inst_out, 32'hdeadbeef);
      chk("hold_release_pc", if_pc_out, 32'h4);
      // branch two cycles into WAIT
      cyc(0, 0, 0, 32'h8, 0);
      cyc(0, 0, 0, 32'h8, 0);
      cyc(1, 0, 0, 32'h100, 0);
      cyc(0, 0, 0, 32'h100, 0);
      cyc(1, 0, 1, 32'h100, 32'h11111111);
      chk("discard_no_pulse", 32'(if_valid_out), 32'd0);
      cyc(0, 0, 0, 32'h100, 0);
      chk("branch_target", mem_addr_out, 32'h100);
      // branch coincident with done
      cyc(1, 0, 1, 32'h200, 32'h22222222);
      chk("brdone_req_low", 32'(mem_req_out), 32'd0);
      cyc(0, 0, 0, 32'h200, 0);
      chk("brdone_target", mem_addr_out, 32'h200);
      // rdy_in low for 5 cycles with an ignored done inside
      for (int i = 0; i < 5; i++) begin
         b_rst = 1; b_rdy = 0; b_br = (i == 1); b_stall = 0; b_done = (i == 2); b_pc = 32'h300; b_data = 32'h33333333;
         step();
      end
      chk("frozen_req", 32'(mem_req_out), 32'd1);
      cyc(0, 0, 1, 32'h300, 32'h44444444);
      chk("resume_inst", if_inst_out, 32'h44444444);
      // reset during WAIT, then a late done while idle
      cyc(0, 0, 0, 32'h400, 0);
      b_rst = 0; b_rdy = 0; b_br = 0; b_stall = 0; b_done = 0; b_pc = 32'h400; b_data = 0;
      step();
      chk("rst_req", 32'(mem_req_out), 32'd0);
      chk("rst_inst", if_inst_out, NOP);
      cyc(1, 0, 1, 32'h400, 32'h55555555);
      chk("late_done_ignored", 32'(if_valid_out), 32'd0);
      // randomized traffic with a latency-randomized memory
      for (int n = 0; n < 4000; n++) begin
         b_rst   = ($urandom_range(0, 99) != 0);
         b_rdy   = ($urandom_range(0, 9) != 0);
         b_br    = ($urandom_range(0, 7) == 0);
         b_stall = 6'($urandom) & {4'hf, ($urandom_range(0, 2) == 0), 1'b1};
         b_pc    = $urandom & 32'hfffffffc;
         b_data  = $urandom;
         b_done  = 0;
         if (m_busy) begin
            if (mem_cnt == 0) b_done = 1;
            else mem_cnt--;
         end else b_done = ($urandom_range(0, 15) == 0);
         pb = m_busy;
         step();
         if (m_busy && !pb) mem_cnt = $urandom_range(0, 5);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
